hazard_ctrl_sb: RTL and testbench
=================================

// Module: hazard_ctrl_sb
// PURPOSE
//  Second-generation hazard and forwarding controller for the MINI-RISC pipeline (F/D/E/M/W).
//  Adds to the existing hazard logic:
//   - a per-register load scoreboard with parameterised load latency;
//   - a three-source forwarding mux select (E, M, W);
//   - a multi-cycle flush FSM for branch/jump redirects;
//   - a saturating stall-cycle counter.
//  Sits beside the decode stage and drives the F/D stall and flush controls plus the ALU operand selects.
// PARAMETERS
//  REG_AW    3   register index width; NREGS = 2**REG_AW; r0 is hardwired zero.
//  LOAD_LAT  1   cycles after E before load data is forwardable (>=1; 1 = classic one-bubble load-use).
//  FLUSH_CYC 1   cycles flush_F/flush_D stay high per redirect (>=1).
//  CNT_W     16  width of stall_cnt.
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-high reset
//  rs1_D       in   REG_AW  decode source register 1
//  rs2_D       in   REG_AW  decode source register 2
//  rs1_use_D   in   1       decode instruction actually reads rs1
//  rs2_use_D   in   1       decode instruction actually reads rs2
//  rd_E        in   REG_AW  execute destination register
//  reg_write_E in   1       execute writes rd_E
//  mem_read_E  in   1       execute is a load
//  rd_M        in   REG_AW  memory-stage destination register
//  reg_write_M in   1       memory stage writes rd_M
//  rd_W        in   REG_AW  writeback destination register
//  reg_write_W in   1       writeback writes rd_W
//  redirect_E  in   1       taken branch/jump resolved in E
//  stall_F     out  1       hold PC
//  stall_D     out  1       hold F/D register
//  bubble_E    out  1       insert NOP into D/E register
//  flush_F     out  1       squash fetch
//  flush_D     out  1       squash F/D register
//  forward_A   out  2       ALU operand A select
//  forward_B   out  2       ALU operand B select
//  stall_cnt   out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  Reset: all scoreboard counters = 0, FSM = IDLE, stall_cnt = 0.
//   Every output is 0 while rst is high.
//  Scoreboard: pend[r] counts down each cycle and saturates at 0.
//   If mem_read_E && reg_write_E && rd_E != 0, pend[rd_E] loads LOAD_LAT-1 at the edge.
//   A new load overrides any count already in progress for that register.
//  Hazard on source s (s = 1 or 2): rsX_use_D && rsX_D != 0 && one of:
//   (a) mem_read_E && reg_write_E && rd_E == rsX_D
//   (b) pend[rsX_D] != 0
//  Any hazard asserts stall_F = stall_D = bubble_E in the same cycle (combinational).
//  Forwarding, per operand, with highest priority first:
//   - E match (reg_write_E, rd_E != 0, !mem_read_E) -> FWD_E
//   - M match -> FWD_M
//   - W match -> FWD_W
//   - otherwise FWD_RF
//   Any match to r0, or to a source whose use bit is 0, gives FWD_RF.
//  Flush FSM, states IDLE and FLUSH; cnt is a down counter:
//   - redirect_E in any state: flush_F = flush_D = 1 in that cycle.
//   - On that redirect, if FLUSH_CYC > 1: next state FLUSH, cnt = FLUSH_CYC-1.
//   - In FLUSH: flush outputs stay high; cnt decrements; cnt == 1 -> IDLE.
//   - A redirect while in FLUSH reloads cnt (restart).
//  Flush beats stall: during any flush cycle, stall_F and stall_D are 0 and bubble_E is 1.
//   The scoreboard is not cleared by a flush; loads already in E/M still complete.
//  stall_cnt increments on every cycle with stall_D = 1 and saturates at all-ones.
//  Reset asserted mid-flush or mid-load: state clears immediately and asynchronously.
//   After release, no stale stall or flush remains.
// STRUCTURE
//  hazard_pkg:
//   - localparams FWD_RF = 2'b00, FWD_E = 2'b01, FWD_M = 2'b10, FWD_W = 2'b11;
//   - flush FSM state encoding.
//  Sub-module hazard_scoreboard (REG_AW, LOAD_LAT):
//   - holds the NREGS x $clog2(LOAD_LAT+1) counters;
//   - outputs a pending bit per read port.
//  Top level: forwarding comparators, flush FSM, stall_cnt.
// TESTING
//  1. LOAD_LAT=1. E: load r3. D: add uses rs1 = r3.
//     -> stall/bubble for exactly 1 cycle. Next cycle forward_A = FWD_M. stall_cnt = 1.
//  2. LOAD_LAT=3. Load r5, then an instruction reads r5.
//     -> stall for 3 consecutive cycles, then forward_B = FWD_W or FWD_RF, matching pipeline position.
//  3. rd_E = rd_M = rd_W = r2, all writing, non-load; rs1_D = r2.
//     -> forward_A = FWD_E. With reg_write_E = 0 -> FWD_M.
//  4. rs1_D = r0, with E/M/W all writing r0 and the E stage a load.
//     -> no stall, forward_A = FWD_RF.
//  5. FLUSH_CYC=2. redirect_E pulses 1 cycle -> flush high for 2 cycles.
//     A second redirect in cycle 2 -> flush held through cycle 3.
//     A load-use hazard during the flush -> stall_F = 0.
//  6. Assert rst while in FLUSH with pend[4] = 2.
//     -> outputs 0 immediately. After release, reading r4 causes no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants for the MINI-RISC hazard/forwarding controller.
//  - forwarding select codes driven on forward_A / forward_B
//  - flush FSM state encoding
//  - helper that resolves the E > M > W > RF forwarding priority
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    // Hit bits already exclude r0 and non-writing stages; use_i masks
    // operands the decode instruction does not actually read.
    function automatic logic [1:0] fwd_sel(input logic use_i,
                                           input logic e_hit,
                                           input logic m_hit,
                                           input logic w_hit);
        if (!use_i)     return FWD_RF;
        else if (e_hit) return FWD_E;
        else if (m_hit) return FWD_M;
        else if (w_hit) return FWD_W;
        else            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register load-latency counters.
//  clk, rst        clock, async active-high reset
//  load_vld_i      a load with a non-zero destination is in E this cycle
//  load_rd_i       destination register of that load
//  rd1_i / rd2_i   decode read-port register indices
//  pend1_o/pend2_o register on that read port still has a load in flight
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_vld_i,
    input  logic [REG_AW-1:0] load_rd_i,
    input  logic [REG_AW-1:0] rd1_i,
    input  logic [REG_AW-1:0] rd2_i,
    output logic              pend1_o,
    output logic              pend2_o
);

    localparam int NREGS = 2 ** REG_AW;
    localparam int PW    = $clog2(LOAD_LAT + 1);
    localparam logic [PW-1:0] LOAD_VAL = PW'(LOAD_LAT - 1);

    logic [PW-1:0] pend_q [NREGS];
    logic [PW-1:0] pend_d [NREGS];

    // Countdown saturates at zero; a new load to the same register restarts it.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - PW'(1) : '0;
            if (load_vld_i && (load_rd_i == REG_AW'(r)))
                pend_d[r] = LOAD_VAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
        end
    end

    assign pend1_o = (pend_q[rd1_i] != '0);
    assign pend2_o = (pend_q[rd2_i] != '0);

endmodule

// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: hazard and forwarding controller beside the decode stage.
//  Inputs : decode sources (rs1_D/rs2_D + use bits), E/M/W destinations and
//           write enables, mem_read_E (E is a load), redirect_E (taken branch).
//  Outputs: stall_F/stall_D/bubble_E load-use interlock, flush_F/flush_D
//           redirect squash, forward_A/forward_B ALU operand selects,
//           stall_cnt saturating count of stalled cycles.
//  All outputs are forced to 0 while rst is high.
module hazard_ctrl_sb
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 3,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic              rs1_use_D,
    input  logic              rs2_use_D,
    input  logic [REG_AW-1:0] rd_E,
    input  logic              reg_write_E,
    input  logic              mem_read_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic              reg_write_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              reg_write_W,
    input  logic              redirect_E,
    output logic              stall_F,
    output logic              stall_D,
    output logic              bubble_E,
    output logic              flush_F,
    output logic              flush_D,
    output logic [1:0]        forward_A,
    output logic [1:0]        forward_B,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYC - 1);

    logic load_vld;
    logic pend1, pend2;
    logic haz1, haz2, stall_raw, flush_any;
    logic e_hit1, m_hit1, w_hit1, e_hit2, m_hit2, w_hit2;

    flush_state_e     state_q;
    logic [FCW-1:0]   cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    assign load_vld = mem_read_E && reg_write_E && (rd_E != '0);

    hazard_scoreboard #(
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .load_vld_i (load_vld),
        .load_rd_i  (rd_E),
        .rd1_i      (rs1_D),
        .rd2_i      (rs2_D),
        .pend1_o    (pend1),
        .pend2_o    (pend2)
    );

    assign haz1 = rs1_use_D && (rs1_D != '0) &&
                  ((load_vld && (rd_E == rs1_D)) || pend1);
    assign haz2 = rs2_use_D && (rs2_D != '0) &&
                  ((load_vld && (rd_E == rs2_D)) || pend2);
    assign stall_raw = haz1 || haz2;

    // A load in E cannot forward from E; it is covered by the interlock.
    assign e_hit1 = reg_write_E && !mem_read_E && (rd_E != '0) && (rd_E == rs1_D);
    assign m_hit1 = reg_write_M && (rd_M != '0) && (rd_M == rs1_D);
    assign w_hit1 = reg_write_W && (rd_W != '0) && (rd_W == rs1_D);
    assign e_hit2 = reg_write_E && !mem_read_E && (rd_E != '0) && (rd_E == rs2_D);
    assign m_hit2 = reg_write_M && (rd_M != '0) && (rd_M == rs2_D);
    assign w_hit2 = reg_write_W && (rd_W != '0) && (rd_W == rs2_D);

    // Redirect cycle flushes combinationally; FLUSH covers the remaining cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (redirect_E) begin
            if (FLUSH_CYC > 1) begin
                state_q <= ST_FLUSH;
                cnt_q   <= FLUSH_RELOAD;
            end
        end else if (state_q == ST_FLUSH) begin
            if (cnt_q == FCW'(1)) state_q <= ST_IDLE;
            cnt_q <= cnt_q - FCW'(1);
        end
    end

    assign flush_any = !rst && (redirect_E || (state_q == ST_FLUSH));

    // Flush wins: the squashed decode instruction must not hold the pipe.
    assign stall_F  = !rst && stall_raw && !flush_any;
    assign stall_D  = !rst && stall_raw && !flush_any;
    assign bubble_E = !rst && (stall_raw || flush_any);
    assign flush_F  = flush_any;
    assign flush_D  = flush_any;

    assign forward_A = rst ? FWD_RF : fwd_sel(rs1_use_D, e_hit1, m_hit1, w_hit1);
    assign forward_B = rst ? FWD_RF : fwd_sel(rs2_use_D, e_hit2, m_hit2, w_hit2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (stall_D && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
module tb_hazard_ctrl_sb;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] rs1_D = '0, rs2_D = '0, rd_E = '0, rd_M = '0, rd_W = '0;
    logic rs1_use_D = 0, rs2_use_D = 0, reg_write_E = 0, mem_read_E = 0;
    logic reg_write_M = 0, reg_write_W = 0, redirect_E = 0;

    typedef struct packed {
        logic sF, sD, bE, fF, fD;
        logic [1:0] fa, fb;
        logic [15:0] cnt;
    } out_t;

    typedef struct packed {
        logic rst;
        logic [2:0] rs1, rs2;
        logic u1, u2;
        logic [2:0] rdE;
        logic weE, mrE;
        logic [2:0] rdM;
        logic weM;
        logic [2:0] rdW;
        logic weW;
        logic redir;
    } in_t;

    logic sF_a, sD_a, bE_a, fF_a, fD_a, sF_b, sD_b, bE_b, fF_b, fD_b;
    logic [1:0] fa_a, fb_a, fa_b, fb_b;
    logic [15:0] cnt_a, cnt_b;
    out_t act_a, act_b;
    assign act_a = {sF_a, sD_a, bE_a, fF_a, fD_a, fa_a, fb_a, cnt_a};
    assign act_b = {sF_b, sD_b, bE_b, fF_b, fD_b, fa_b, fb_b, cnt_b};

    hazard_ctrl_sb #(.REG_AW(3), .LOAD_LAT(1), .FLUSH_CYC(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .rs1_use_D(rs1_use_D), .rs2_use_D(rs2_use_D), .rd_E(rd_E),
        .reg_write_E(reg_write_E), .mem_read_E(mem_read_E), .rd_M(rd_M),
        .reg_write_M(reg_write_M), .rd_W(rd_W), .reg_write_W(reg_write_W),
        .redirect_E(redirect_E), .stall_F(sF_a), .stall_D(sD_a), .bubble_E(bE_a),
        .flush_F(fF_a), .flush_D(fD_a), .forward_A(fa_a), .forward_B(fb_a),
        .stall_cnt(cnt_a));

    hazard_ctrl_sb #(.REG_AW(3), .LOAD_LAT(3), .FLUSH_CYC(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .rs1_use_D(rs1_use_D), .rs2_use_D(rs2_use_D), .rd_E(rd_E),
        .reg_write_E(reg_write_E), .mem_read_E(mem_read_E), .rd_M(rd_M),
        .reg_write_M(reg_write_M), .rd_W(rd_W), .reg_write_W(reg_write_W),
        .redirect_E(redirect_E), .stall_F(sF_b), .stall_D(sD_b), .bubble_E(bE_b),
        .flush_F(fF_b), .flush_D(fD_b), .forward_A(fa_b), .forward_B(fb_b),
        .stall_cnt(cnt_b));

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle numbers instead of countdown registers.
    // ready_cyc[k][r]: first cycle at which register r no longer interlocks.
    // flush_until[k]:  last cycle covered by the most recent redirect.
    int ll_tab[2] = '{1, 3};
    int fc_tab[2] = '{1, 2};
    int ready_cyc[2][8];
    int flush_until[2];
    int scnt[2];
    bit stl[2];
    int cyc = 0;

    out_t qa[$];
    out_t qb[$];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 8; r++) ready_cyc[k][r] = 0;
            flush_until[k] = -1;
            scnt[k] = 0;
            stl[k] = 0;
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [2:0] rs, input logic use_, input in_t x);
        if (!use_ || rs == 3'd0)           return FWD_RF;
        if (x.weE && !x.mrE && x.rdE == rs) return FWD_E;
        if (x.weM && x.rdM == rs)           return FWD_M;
        if (x.weW && x.rdW == rs)           return FWD_W;
        return FWD_RF;
    endfunction

    task automatic push_exp(input in_t x);
        out_t e;
        logic ld, h1, h2, fl;
        for (int k = 0; k < 2; k++) begin
            e = '0;
            if (!x.rst) begin
                ld = x.mrE && x.weE && (x.rdE != 3'd0);
                h1 = x.u1 && (x.rs1 != 3'd0) &&
                     ((ld && x.rdE == x.rs1) || (cyc < ready_cyc[k][x.rs1]));
                h2 = x.u2 && (x.rs2 != 3'd0) &&
                     ((ld && x.rdE == x.rs2) || (cyc < ready_cyc[k][x.rs2]));
                fl = x.redir || (cyc <= flush_until[k]);
                e.sF  = (h1 || h2) && !fl;
                e.sD  = (h1 || h2) && !fl;
                e.bE  = h1 || h2 || fl;
                e.fF  = fl;
                e.fD  = fl;
                e.fa  = ref_fwd(x.rs1, x.u1, x);
                e.fb  = ref_fwd(x.rs2, x.u2, x);
                e.cnt = 16'(scnt[k]);
            end
            stl[k] = e.sD;
            if (k == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
    endtask

    task automatic model_update(input in_t x);
        if (x.rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (stl[k] && scnt[k] < 65535) scnt[k]++;
                if (x.mrE && x.weE && x.rdE != 3'd0) ready_cyc[k][x.rdE] = cyc + ll_tab[k];
                if (x.redir) flush_until[k] = cyc + fc_tab[k] - 1;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Called at posedge+1; outputs are checked by the monitor at the negedge.
    task automatic step(input in_t x, input bit pulse);
        rs1_D = x.rs1; rs2_D = x.rs2; rs1_use_D = x.u1; rs2_use_D = x.u2;
        rd_E = x.rdE; reg_write_E = x.weE; mem_read_E = x.mrE;
        rd_M = x.rdM; reg_write_M = x.weM; rd_W = x.rdW; reg_write_W = x.weW;
        redirect_E = x.redir;
        rst = x.rst;
        if (pulse && !x.rst) begin
            rst = 1'b1;
            #1;
            chk("async_rst_outputs_zero", {act_a[20:0], 11'd0} | {11'd0, act_b[20:0]}, 32'd0);
            #1;
            rst = 1'b0;
            model_reset();
        end
        push_exp(x);
        @(posedge clk);
        #1;
        model_update(x);
    endtask

    always @(negedge clk) begin
        out_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("A_stall", {29'd0, act_a.sF, act_a.sD, act_a.bE}, {29'd0, e.sF, e.sD, e.bE});
            chk("A_flush", {30'd0, act_a.fF, act_a.fD}, {30'd0, e.fF, e.fD});
            chk("A_fwd",   {28'd0, act_a.fa, act_a.fb}, {28'd0, e.fa, e.fb});
            chk("A_cnt",   {16'd0, act_a.cnt}, {16'd0, e.cnt});
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("B_stall", {29'd0, act_b.sF, act_b.sD, act_b.bE}, {29'd0, e.sF, e.sD, e.bE});
            chk("B_flush", {30'd0, act_b.fF, act_b.fD}, {30'd0, e.fF, e.fD});
            chk("B_fwd",   {28'd0, act_b.fa, act_b.fb}, {28'd0, e.fa, e.fb});
            chk("B_cnt",   {16'd0, act_b.cnt}, {16'd0, e.cnt});
        end
    end

    in_t x;
    initial begin
        model_reset();
        @(posedge clk); #1;
        x = '0; x.rst = 1'b1;
        step(x, 0); step(x, 0);

        // load r3 in E, decode reads r3; then load moves to M
        x = '0; x.rdE = 3; x.weE = 1; x.mrE = 1; x.rs1 = 3; x.u1 = 1; step(x, 0);
        x = '0; x.rdM = 3; x.weM = 1; x.rs1 = 3; x.u1 = 1; step(x, 0);
        x = '0; step(x, 0);

        // load r5, reader held while load walks through M and W
        x = '0; x.rdE = 5; x.weE = 1; x.mrE = 1; x.rs2 = 5; x.u2 = 1; step(x, 0);
        x = '0; x.rdM = 5; x.weM = 1; x.rs2 = 5; x.u2 = 1; step(x, 0);
        x = '0; x.rdW = 5; x.weW = 1; x.rs2 = 5; x.u2 = 1; step(x, 0);
        x = '0; x.rs2 = 5; x.u2 = 1; step(x, 0);
        x = '0; x.rdW = 5; x.weW = 1; x.rs2 = 5; x.u2 = 1; step(x, 0);

        // E/M/W all write r2
        x = '0; x.rdE = 2; x.weE = 1; x.rdM = 2; x.weM = 1; x.rdW = 2; x.weW = 1;
        x.rs1 = 2; x.u1 = 1; step(x, 0);
        x.weE = 0; step(x, 0);
        x.weM = 0; step(x, 0);
        x.u1 = 0; step(x, 0);

        // r0 everywhere, E a load
        x = '0; x.weE = 1; x.mrE = 1; x.weM = 1; x.weW = 1; x.u1 = 1; x.u2 = 1; step(x, 0);

        // redirects: single, back-to-back, with load-use hazard
        x = '0; x.redir = 1; step(x, 0);
        x = '0; step(x, 0); step(x, 0);
        x = '0; x.redir = 1; step(x, 0); step(x, 0);
        x = '0; step(x, 0); step(x, 0);
        x = '0; x.redir = 1; x.rdE = 6; x.weE = 1; x.mrE = 1; x.rs1 = 6; x.u1 = 1; step(x, 0);
        x = '0; x.rs1 = 6; x.u1 = 1; step(x, 0); step(x, 0);
        x = '0; step(x, 0); step(x, 0);

        // reset during FLUSH with r4 pending, then read r4
        x = '0; x.redir = 1; x.rdE = 4; x.weE = 1; x.mrE = 1; step(x, 0);
        x = '0; x.rs1 = 4; x.u1 = 1; step(x, 1);
        step(x, 0);
        x = '0; x.redir = 1; x.rdE = 4; x.weE = 1; x.mrE = 1; step(x, 0);
        x = '0; x.rst = 1; x.rs1 = 4; x.u1 = 1; step(x, 0);
        x.rst = 0; step(x, 0);

        for (int i = 0; i < 1500; i++) begin
            x = '0;
            x.rst   = ($urandom_range(0, 99) == 0);
            x.rs1   = 3'($urandom_range(0, 4));
            x.rs2   = 3'($urandom_range(0, 4));
            x.u1    = 1'($urandom_range(0, 1));
            x.u2    = 1'($urandom_range(0, 1));
            x.rdE   = 3'($urandom_range(0, 4));
            x.weE   = 1'($urandom_range(0, 1));
            x.mrE   = ($urandom_range(0, 2) == 0);
            x.rdM   = 3'($urandom_range(0, 4));
            x.weM   = 1'($urandom_range(0, 1));
            x.rdW   = 3'($urandom_range(0, 4));
            x.weW   = 1'($urandom_range(0, 1));
            x.redir = ($urandom_range(0, 7) == 0);
            step(x, $urandom_range(0, 149) == 0);
        end

        x = '0; step(x, 0);
        @(negedge clk); #1;
        chk("scoreboard_drained", qa.size() + qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
